// File: rtl/pcie_tx_arbiter.sv
// Two-requester, packet-atomic round-robin arbiter for the 64-bit PCIe core TX stream.
// A grant is held from the first beat through tlast; one IDLE bubble separates packets.
module pcie_tx_arbiter #(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter int TUSER_WIDTH  = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    sys_rst_n,

    input  logic                    s0_axis_tx_tvalid,
    output logic                    s0_axis_tx_tready,
    input  logic                    s0_axis_tx_tlast,
    input  logic [C_DATA_WIDTH-1:0] s0_axis_tx_tdata,
    input  logic [KEEP_WIDTH-1:0]   s0_axis_tx_tkeep,
    input  logic [TUSER_WIDTH-1:0]  s0_axis_tx_tuser,

    input  logic                    s1_axis_tx_tvalid,
    output logic                    s1_axis_tx_tready,
    input  logic                    s1_axis_tx_tlast,
    input  logic [C_DATA_WIDTH-1:0] s1_axis_tx_tdata,
    input  logic [KEEP_WIDTH-1:0]   s1_axis_tx_tkeep,
    input  logic [TUSER_WIDTH-1:0]  s1_axis_tx_tuser,

    output logic                    m_axis_tx_tvalid,
    input  logic                    m_axis_tx_tready,
    output logic                    m_axis_tx_tlast,
    output logic [C_DATA_WIDTH-1:0] m_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tx_tkeep,
    output logic [TUSER_WIDTH-1:0]  m_axis_tx_tuser,

    output logic [1:0]              grant,
    output logic [CNT_WIDTH-1:0]    pkt_cnt0,
    output logic [CNT_WIDTH-1:0]    pkt_cnt1,
    output logic [1:0]              state_dbg
);

    // Handshake: a beat transfers on a rising edge where tvalid and tready are both high;
    // the source holds tvalid and payload stable until then, and tready may depend on tvalid.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q;
    logic   done0, done1;

    always_comb begin
        state_d           = state_q;
        m_axis_tx_tvalid  = 1'b0;
        m_axis_tx_tlast   = 1'b0;
        m_axis_tx_tdata   = '0;
        m_axis_tx_tkeep   = '0;
        m_axis_tx_tuser   = '0;
        s0_axis_tx_tready = 1'b0;
        s1_axis_tx_tready = 1'b0;
        grant             = 2'b00;
        done0             = 1'b0;
        done1             = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie, the requester that did not own the link last time wins.
                if (s0_axis_tx_tvalid && s1_axis_tx_tvalid)
                    state_d = last_q ? GNT0 : GNT1;
                else if (s0_axis_tx_tvalid)
                    state_d = GNT0;
                else if (s1_axis_tx_tvalid)
                    state_d = GNT1;
            end
            GNT0: begin
                m_axis_tx_tvalid  = s0_axis_tx_tvalid;
                m_axis_tx_tlast   = s0_axis_tx_tlast;
                m_axis_tx_tdata   = s0_axis_tx_tdata;
                m_axis_tx_tkeep   = s0_axis_tx_tkeep;
                m_axis_tx_tuser   = s0_axis_tx_tuser;
                s0_axis_tx_tready = m_axis_tx_tready;
                grant             = 2'b01;
                done0 = s0_axis_tx_tvalid && m_axis_tx_tready && s0_axis_tx_tlast;
                if (done0)
                    state_d = IDLE;
            end
            GNT1: begin
                m_axis_tx_tvalid  = s1_axis_tx_tvalid;
                m_axis_tx_tlast   = s1_axis_tx_tlast;
                m_axis_tx_tdata   = s1_axis_tx_tdata;
                m_axis_tx_tkeep   = s1_axis_tx_tkeep;
                m_axis_tx_tuser   = s1_axis_tx_tuser;
                s1_axis_tx_tready = m_axis_tx_tready;
                grant             = 2'b10;
                done1 = s1_axis_tx_tvalid && m_axis_tx_tready && s1_axis_tx_tlast;
                if (done1)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && state_d == GNT0)
                last_q <= 1'b0;
            else if (state_q == IDLE && state_d == GNT1)
                last_q <= 1'b1;
            if (done0)
                pkt_cnt0 <= pkt_cnt0 + 1'b1;
            if (done1)
                pkt_cnt1 <= pkt_cnt1 + 1'b1;
        end
    end

    assign state_dbg = state_q;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Bench for pcie_tx_arbiter: cycle-by-cycle vector table plus hand-written
// sequences for counter wrap and reset in the middle of a packet.
module tb_pcie_tx_arbiter;

    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        s0_tvalid, s0_tready, s0_tlast;
    logic [63:0] s0_tdata;
    logic [7:0]  s0_tkeep;
    logic [3:0]  s0_tuser;
    logic        s1_tvalid, s1_tready, s1_tlast;
    logic [63:0] s1_tdata;
    logic [7:0]  s1_tkeep;
    logic [3:0]  s1_tuser;
    logic        m_tvalid, m_tready, m_tlast;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic [3:0]  m_tuser;
    logic [1:0]  grant;
    logic [CW-1:0] pkt_cnt0, pkt_cnt1;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    pcie_tx_arbiter #(.C_DATA_WIDTH(64), .KEEP_WIDTH(8), .TUSER_WIDTH(4), .CNT_WIDTH(CW)) dut (
        .clk(clk), .sys_rst_n(sys_rst_n),
        .s0_axis_tx_tvalid(s0_tvalid), .s0_axis_tx_tready(s0_tready), .s0_axis_tx_tlast(s0_tlast),
        .s0_axis_tx_tdata(s0_tdata), .s0_axis_tx_tkeep(s0_tkeep), .s0_axis_tx_tuser(s0_tuser),
        .s1_axis_tx_tvalid(s1_tvalid), .s1_axis_tx_tready(s1_tready), .s1_axis_tx_tlast(s1_tlast),
        .s1_axis_tx_tdata(s1_tdata), .s1_axis_tx_tkeep(s1_tkeep), .s1_axis_tx_tuser(s1_tuser),
        .m_axis_tx_tvalid(m_tvalid), .m_axis_tx_tready(m_tready), .m_axis_tx_tlast(m_tlast),
        .m_axis_tx_tdata(m_tdata), .m_axis_tx_tkeep(m_tkeep), .m_axis_tx_tuser(m_tuser),
        .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Scoreboard: every accepted beat on the master side must match the next expected beat.
    always @(negedge clk) begin
        if (sys_rst_n && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_beat", m_tdata, 64'h0);
            end else begin
                chk("sb_beat_data", m_tdata, exp_q.pop_front());
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic rst;
        logic s0v; logic s0l; logic [63:0] s0d; logic [7:0] s0k;
        logic s1v; logic s1l; logic [63:0] s1d; logic [7:0] s1k;
        logic mrdy;
        logic mv; logic ml; logic [63:0] md; logic [7:0] mk; logic [3:0] mu;
        logic [1:0] g; logic r0; logic r1; logic [CW-1:0] c0; logic [CW-1:0] c1;
    } vec_t;

    localparam logic [63:0] D11 = 64'h1111_1111_1111_1111, D22 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] D33 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] PA0 = 64'hA0A0_0000_0000_00A0, PA1 = 64'hA1A1_0000_0000_00A1;
    localparam logic [63:0] PB0 = 64'hB0B0_0000_0000_00B0, PB1 = 64'hB1B1_0000_0000_00B1;
    localparam logic [63:0] PC0 = 64'hC0C0_0000_0000_00C0, PC1 = 64'hC1C1_0000_0000_00C1;
    localparam logic [63:0] PD0 = 64'hD0D0_0000_0000_00D0, PD1 = 64'hD1D1_0000_0000_00D1;
    localparam logic [63:0] PE0 = 64'hE0E0_0000_0000_00E0, PE1 = 64'hE1E1_0000_0000_00E1;
    localparam logic [63:0] PE2 = 64'hE2E2_0000_0000_00E2, PE3 = 64'hE3E3_0000_0000_00E3;
    localparam logic [63:0] PE4 = 64'hE4E4_0000_0000_00E4;
    localparam logic [63:0] PF0 = 64'hF0F0_0000_0000_00F0, PF1 = 64'hF1F1_0000_0000_00F1;
    localparam logic [63:0] PF2 = 64'hF2F2_0000_0000_00F2, PG0 = 64'h6060_0000_0000_0060;

    localparam int NV = 37;
    vec_t vecs[NV];

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        s0_tvalid = 0; s0_tlast = 0; s0_tdata = '0; s0_tkeep = '0;
        s1_tvalid = 0; s1_tlast = 0; s1_tdata = '0; s1_tkeep = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        sys_rst_n = 0;
        m_tready  = 1;
        step();
        sys_rst_n = 1;
    endtask

    // Sends nbeats from requester req; if abort_beat >= 0, reset is asserted while
    // that beat is being presented and the task returns with reset still low.
    task automatic send_pkt(input int req, input int nbeats, input logic [63:0] base, input int abort_beat);
        int cyc;
        for (int b = 0; b < nbeats; b++) begin
            if (req == 0) begin
                s0_tvalid = 1; s0_tdata = base + 64'(b); s0_tkeep = 8'hFF; s0_tlast = (b == nbeats - 1);
            end else begin
                s1_tvalid = 1; s1_tdata = base + 64'(b); s1_tkeep = 8'hFF; s1_tlast = (b == nbeats - 1);
            end
            if (b == abort_beat) begin
                sys_rst_n = 0;
                #1;
                return;
            end
            exp_q.push_back(base + 64'(b));
            cyc = 0;
            forever begin
                @(negedge clk);
                if ((req == 0) ? s0_tready : s1_tready) break;
                cyc++;
                if (cyc > 10) begin
                    chk("send_pkt_timeout", 64'(cyc), 64'd0);
                    idle_inputs();
                    return;
                end
                step();
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        s0_tuser = 4'h3;
        s1_tuser = 4'hC;
        //            rst s0v s0l s0d  s0k    s1v s1l s1d  s1k    rdy mv ml md   mk     mu    g      r0 r1 c0 c1
        vecs[0]  = '{1, 1, 0, D11, 8'hFF, 1, 0, PB0, 8'hFF, 1, 0, 0, 0,   8'h00, 4'h0, 2'b00, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0,   8'h00, 0, 0, 0,   8'h00, 1, 0, 0, 0,   8'h00, 4'h0, 2'b00, 0, 0, 0, 0};
        vecs[2]  = '{0, 1, 0, D11, 8'hFF, 0, 0, 0,   8'h00, 1, 0, 0, 0,   8'h00, 4'h0, 2'b00, 0, 0, 0, 0};
        vecs[3]  = '{0, 1, 0, D11, 8'hFF, 0, 0, 0,   8'h00, 1, 1, 0, D11, 8'hFF, 4'h3, 2'b01, 1, 0, 0, 0};
        vecs[4]  = '{0, 1, 0, D22, 8'hFF, 0, 0, 0,   8'h00, 1, 1, 0, D22, 8'hFF, 4'h3, 2'b01, 1, 0, 0, 0};
        vecs[5]  = '{0, 1, 1, D33, 8'h0F, 0, 0, 0,   8'h00, 1, 1, 1, D33, 8'h0F, 4'h3, 2'b01, 1, 0, 0, 0};
        vecs[6]  = '{0, 0, 0, 0,   8'h00, 0, 0, 0,   8'h00, 1, 0, 0, 0,   8'h00, 4'h0, 2'b00, 0, 0, 1, 0};
        vecs[7]  = '{1, 0, 0, 0,   8'h00, 0, 0, 0,   8'h00, 1, 0, 0, 0,   8'h00, 4'h0, 2'b00, 0, 0, 0, 0};
        vecs[8]  = '{0, 1, 0, PA0, 8'hFF, 1, 0, PB0, 8'hFF, 1, 0, 0, 0,   8'h00, 4'h0, 2'b00, 0, 0, 0, 0};
        vecs[9]  = '{0, 1, 0, PA0, 8'hFF, 1, 0, PB0, 8'hFF, 1, 1, 0, PA0, 8'hFF, 4'h3, 2'b01, 1, 0, 0, 0};
        vecs[10] = '{0, 1, 1, PA1, 8'hFF, 1, 0, PB0, 8'hFF, 1, 1, 1, PA1, 8'hFF, 4'h3, 2'b01, 1, 0, 0, 0};
        vecs[11] = '{0, 1, 0, PC0, 8'hFF, 1, 0, PB0, 8'hFF, 1, 0, 0, 0,   8'h00, 4'h0, 2'b00, 0, 0, 1, 0};
        vecs[12] = '{0, 1, 0, PC0, 8'hFF, 1, 0, PB0, 8'hFF, 1, 1, 0, PB0, 8'hFF, 4'hC, 2'b10, 0, 1, 1, 0};
        vecs[13] = '{0, 1, 0, PC0, 8'hFF, 1, 1, PB1, 8'hFF, 1, 1, 1, PB1, 8'hFF, 4'hC, 2'b10, 0, 1, 1, 0};
        vecs[14] = '{0, 1, 0, PC0, 8'hFF, 1, 0, PD0, 8'hFF, 1, 0, 0, 0,   8'h00, 4'h0, 2'b00, 0, 0, 1, 1};
        vecs[15] = '{0, 1, 0, PC0, 8'hFF, 1, 0, PD0, 8'hFF, 1, 1, 0, PC0, 8'hFF, 4'h3, 2'b01, 1, 0, 1, 1};
        vecs[16] = '{0, 1, 1, PC1, 8'hFF, 1, 0, PD0, 8'hFF, 1, 1, 1, PC1, 8'hFF, 4'h3, 2'b01, 1, 0, 1, 1};
        vecs[17] = '{0, 1, 0, PE0, 8'hFF, 1, 0, PD0, 8'hFF, 1, 0, 0, 0,   8'h00, 4'h0, 2'b00, 0, 0, 2, 1};
        vecs[18] = '{0, 1, 0, PE0, 8'hFF, 1, 0, PD0, 8'hFF, 1, 1, 0, PD0, 8'hFF, 4'hC, 2'b10, 0, 1, 2, 1};
        vecs[19] = '{0, 1, 0, PE0, 8'hFF, 1, 1, PD1, 8'hFF, 1, 1, 1, PD1, 8'hFF, 4'hC, 2'b10, 0, 1, 2, 1};
        vecs[20] = '{0, 1, 0, PE0, 8'hFF, 0, 0, 0,   8'h00, 1, 0, 0, 0,   8'h00, 4'h0, 2'b00, 0, 0, 2, 2};
        vecs[21] = '{0, 1, 0, PE0, 8'hFF, 0, 0, 0,   8'h00, 1, 1, 0, PE0, 8'hFF, 4'h3, 2'b01, 1, 0, 2, 2};
        vecs[22] = '{0, 1, 0, PE1, 8'hFF, 1, 0, PF0, 8'hFF, 1, 1, 0, PE1, 8'hFF, 4'h3, 2'b01, 1, 0, 2, 2};
        vecs[23] = '{0, 1, 0, PE2, 8'hFF, 1, 0, PF0, 8'hFF, 1, 1, 0, PE2, 8'hFF, 4'h3, 2'b01, 1, 0, 2, 2};
        vecs[24] = '{0, 1, 0, PE3, 8'hFF, 1, 0, PF0, 8'hFF, 1, 1, 0, PE3, 8'hFF, 4'h3, 2'b01, 1, 0, 2, 2};
        vecs[25] = '{0, 1, 1, PE4, 8'hFF, 1, 0, PF0, 8'hFF, 1, 1, 1, PE4, 8'hFF, 4'h3, 2'b01, 1, 0, 2, 2};
        vecs[26] = '{0, 0, 0, 0,   8'h00, 1, 0, PF0, 8'hFF, 1, 0, 0, 0,   8'h00, 4'h0, 2'b00, 0, 0, 3, 2};
        vecs[27] = '{0, 0, 0, 0,   8'h00, 1, 0, PF0, 8'hFF, 1, 1, 0, PF0, 8'hFF, 4'hC, 2'b10, 0, 1, 3, 2};
        vecs[28] = '{0, 0, 0, 0,   8'h00, 1, 0, PF1, 8'hFF, 0, 1, 0, PF1, 8'hFF, 4'hC, 2'b10, 0, 0, 3, 2};
        vecs[29] = '{0, 0, 0, 0,   8'h00, 1, 0, PF1, 8'hFF, 0, 1, 0, PF1, 8'hFF, 4'hC, 2'b10, 0, 0, 3, 2};
        vecs[30] = '{0, 0, 0, 0,   8'h00, 1, 0, PF1, 8'hFF, 0, 1, 0, PF1, 8'hFF, 4'hC, 2'b10, 0, 0, 3, 2};
        vecs[31] = '{0, 0, 0, 0,   8'h00, 1, 0, PF1, 8'hFF, 1, 1, 0, PF1, 8'hFF, 4'hC, 2'b10, 0, 1, 3, 2};
        vecs[32] = '{0, 0, 0, 0,   8'h00, 1, 1, PF2, 8'h3C, 1, 1, 1, PF2, 8'h3C, 4'hC, 2'b10, 0, 1, 3, 2};
        vecs[33] = '{0, 1, 1, PG0, 8'hFF, 0, 0, 0,   8'h00, 0, 0, 0, 0,   8'h00, 4'h0, 2'b00, 0, 0, 3, 3};
        vecs[34] = '{0, 1, 1, PG0, 8'hFF, 0, 0, 0,   8'h00, 0, 1, 1, PG0, 8'hFF, 4'h3, 2'b01, 0, 0, 3, 3};
        vecs[35] = '{0, 1, 1, PG0, 8'hFF, 0, 0, 0,   8'h00, 1, 1, 1, PG0, 8'hFF, 4'h3, 2'b01, 1, 0, 3, 3};
        vecs[36] = '{0, 0, 0, 0,   8'h00, 0, 0, 0,   8'h00, 1, 0, 0, 0,   8'h00, 4'h0, 2'b00, 0, 0, 4, 3};

        sys_rst_n = 0;
        m_tready  = 1;
        idle_inputs();
        step();
        step();

        // ---- table: single packet, round robin, no preemption, back-pressure ----
        for (int i = 0; i < NV; i++) begin
            sys_rst_n = !vecs[i].rst;
            s0_tvalid = vecs[i].s0v; s0_tlast = vecs[i].s0l; s0_tdata = vecs[i].s0d; s0_tkeep = vecs[i].s0k;
            s1_tvalid = vecs[i].s1v; s1_tlast = vecs[i].s1l; s1_tdata = vecs[i].s1d; s1_tkeep = vecs[i].s1k;
            m_tready  = vecs[i].mrdy;
            if (vecs[i].mv && vecs[i].mrdy && !vecs[i].rst)
                exp_q.push_back(vecs[i].md);
            @(negedge clk);
            chk($sformatf("v%0d_m_tvalid", i), 64'(m_tvalid), 64'(vecs[i].mv));
            chk($sformatf("v%0d_m_tlast", i), 64'(m_tlast), 64'(vecs[i].ml));
            chk($sformatf("v%0d_m_tdata", i), m_tdata, vecs[i].md);
            chk($sformatf("v%0d_m_tkeep", i), 64'(m_tkeep), 64'(vecs[i].mk));
            chk($sformatf("v%0d_m_tuser", i), 64'(m_tuser), 64'(vecs[i].mu));
            chk($sformatf("v%0d_grant", i), 64'(grant), 64'(vecs[i].g));
            chk($sformatf("v%0d_s0_tready", i), 64'(s0_tready), 64'(vecs[i].r0));
            chk($sformatf("v%0d_s1_tready", i), 64'(s1_tready), 64'(vecs[i].r1));
            chk($sformatf("v%0d_pkt_cnt0", i), 64'(pkt_cnt0), 64'(vecs[i].c0));
            chk($sformatf("v%0d_pkt_cnt1", i), 64'(pkt_cnt1), 64'(vecs[i].c1));
            step();
        end

        // ---- counter wrap: 17 one-beat packets from s0 ----
        do_reset();
        chk("wrap_cnt0_start", 64'(pkt_cnt0), 64'd0);
        for (int i = 1; i <= 17; i++) begin
            send_pkt(0, 1, 64'h5000 + 64'(i), -1);
            chk($sformatf("wrap_cnt0_after_%0d", i), 64'(pkt_cnt0), 64'(i % 16));
        end

        // ---- reset in the middle of an s1 packet ----
        do_reset();
        send_pkt(1, 1, 64'h7000, -1);
        chk("rst_pre_cnt1", 64'(pkt_cnt1), 64'd1);
        send_pkt(1, 4, 64'h7100, 2);
        chk("rst_mid_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_mid_grant", 64'(grant), 64'd0);
        chk("rst_mid_cnt1", 64'(pkt_cnt1), 64'd0);
        chk("rst_mid_s1_tready", 64'(s1_tready), 64'd0);
        idle_inputs();
        step();
        sys_rst_n = 1;
        step();
        s0_tvalid = 1; s0_tlast = 1; s0_tdata = 64'h8000; s0_tkeep = 8'hFF;
        s1_tvalid = 1; s1_tlast = 1; s1_tdata = 64'h8100; s1_tkeep = 8'hFF;
        exp_q.push_back(64'h8000);
        @(negedge clk);
        chk("tie_idle_grant", 64'(grant), 64'd0);
        step();
        @(negedge clk);
        chk("tie_grant_s0", 64'(grant), 64'h1);
        chk("tie_s0_tready", 64'(s0_tready), 64'd1);
        chk("tie_s1_tready", 64'(s1_tready), 64'd0);
        step();
        s0_tvalid = 0; s0_tlast = 0;
        exp_q.push_back(64'h8100);
        @(negedge clk);
        chk("tie_bubble_grant", 64'(grant), 64'd0);
        step();
        @(negedge clk);
        chk("tie_grant_s1", 64'(grant), 64'h2);
        step();
        s1_tvalid = 0; s1_tlast = 0;
        @(negedge clk);
        chk("tie_end_cnt0", 64'(pkt_cnt0), 64'd1);
        chk("tie_end_cnt1", 64'(pkt_cnt1), 64'd1);
        chk("sb_leftover_beats", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
